// File: rtl/ibex_wb_arb_pkg.sv
// Shared types and constants for the Ibex instruction/data Wishbone arbiter.
package ibex_wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_I = 2'd1,
    OWN_D = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } owner_t;

  localparam logic [3:0] INSTR_SEL = 4'hF;

endpackage

// File: rtl/ibex_wb_arbiter.sv
// Shares one pipelined Wishbone master between the Ibex fetch and data ports.
// Define IBEX_WB_ARB_ROUND_ROBIN_EN for round-robin instead of fixed data priority.
//
// state | meaning
// IDLE  | no owner, arbitrating; no strobe
// OWN_I | fetch port owns the bus
// OWN_D | load/store port owns the bus
module ibex_wb_arbiter
  import ibex_wb_arb_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        instr_req,
  output logic        instr_gnt,
  output logic        instr_rvalid,
  input  logic [31:0] instr_addr,
  output logic [31:0] instr_rdata,
  output logic        instr_err,
  input  logic        data_req,
  output logic        data_gnt,
  output logic        data_rvalid,
  input  logic        data_we,
  input  logic [3:0]  data_be,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] data_rdata,
  output logic        data_err,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  input  logic        wb_stall,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic [31:0] wb_dat_i
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  arb_state_t       state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             owner_req, other_req, yield;
  logic             accept, resp, cnt_nz;

  assign cnt_nz = (cnt != '0);
  assign resp   = (wb_ack | wb_err) & cnt_nz;
  assign accept = wb_stb & ~wb_stall;

  always_comb begin
    owner_req = 1'b0;
    other_req = 1'b0;
    wb_adr    = '0;
    wb_sel    = '0;
    wb_we     = 1'b0;
    wb_dat_o  = '0;
    case (state)
      OWN_I: begin
        owner_req = instr_req;
        other_req = data_req;
        wb_adr    = instr_addr;
        wb_sel    = INSTR_SEL;
      end
      OWN_D: begin
        owner_req = data_req;
        other_req = instr_req;
        wb_adr    = data_addr;
        wb_sel    = data_be;
        wb_we     = data_we;
        wb_dat_o  = data_wdata;
      end
      default: ;
    endcase
  end

`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
  owner_t prev_owner;
  logic   had_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_owner <= OWNER_I;
      had_accept <= 1'b0;
    end else begin
      if (state == IDLE)  had_accept <= 1'b0;
      else if (accept)    had_accept <= 1'b1;
      if (state == IDLE && state_next == OWN_D)      prev_owner <= OWNER_D;
      else if (state == IDLE && state_next == OWN_I) prev_owner <= OWNER_I;
    end
  end

  assign yield = other_req & had_accept;
`else
  assign yield = (state == OWN_I) & other_req;
`endif

  assign wb_stb = owner_req & ~yield & (cnt < MAX_CNT);
  assign wb_cyc = (state != IDLE) & (wb_stb | cnt_nz);

  assign instr_gnt    = (state == OWN_I) & accept;
  assign data_gnt     = (state == OWN_D) & accept;
  assign instr_rvalid = (state == OWN_I) & resp;
  assign data_rvalid  = (state == OWN_D) & resp;
  assign instr_err    = (state == OWN_I) & wb_err & cnt_nz;
  assign data_err     = (state == OWN_D) & wb_err & cnt_nz;
  assign instr_rdata  = wb_dat_i;
  assign data_rdata   = wb_dat_i;

  always_comb begin
    cnt_next = cnt;
    if (accept && !resp)      cnt_next = cnt + 1'b1;
    else if (!accept && resp) cnt_next = cnt - 1'b1;
  end

  // Ownership is only released once every outstanding response has returned.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
        if (data_req && instr_req) state_next = (prev_owner == OWNER_D) ? OWN_I : OWN_D;
        else if (data_req)         state_next = OWN_D;
        else if (instr_req)        state_next = OWN_I;
`else
        if (data_req)       state_next = OWN_D;
        else if (instr_req) state_next = OWN_I;
`endif
      end
      default: begin
        if (cnt_next == '0 && (!owner_req || yield)) state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

endmodule

// File: tb/tb_ibex_wb_arbiter.sv
// Self-checking bench for ibex_wb_arbiter: vector table, corner-case sequences, random vs. model.
module tb_ibex_wb_arbiter;

  localparam int          MAXO = 2;
  localparam logic [31:0] IA   = 32'h0000_0100;
  localparam logic [31:0] DA   = 32'h2000_0010;
  localparam logic [31:0] WD   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        wb_cyc, wb_stb, wb_we, wb_stall, wb_ack, wb_err;
  logic [31:0] wb_adr, wb_dat_o, wb_dat_i;
  logic [3:0]  wb_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ibex_wb_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_req(instr_req), .instr_gnt(instr_gnt), .instr_rvalid(instr_rvalid),
    .instr_addr(instr_addr), .instr_rdata(instr_rdata), .instr_err(instr_err),
    .data_req(data_req), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_rdata(data_rdata), .data_err(data_err),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_adr(wb_adr), .wb_dat_o(wb_dat_o),
    .wb_we(wb_we), .wb_sel(wb_sel), .wb_stall(wb_stall), .wb_ack(wb_ack),
    .wb_err(wb_err), .wb_dat_i(wb_dat_i)
  );

  typedef struct {
    logic        ireq, dreq, stall, ack, err;
    logic        stb, cyc, igt, dgt, irv, drv, derr;
    logic [3:0]  sel;
    logic        we;
    logic [31:0] adr, dat;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input bit stb, cyc, igt, dgt, irv, drv, ierr, derr,
                         input logic [3:0] sel, input bit we, input logic [31:0] adr, dat);
    chk({tag, ".stb"}, wb_stb, stb);
    chk({tag, ".cyc"}, wb_cyc, cyc);
    chk({tag, ".igt"}, instr_gnt, igt);
    chk({tag, ".dgt"}, data_gnt, dgt);
    chk({tag, ".irv"}, instr_rvalid, irv);
    chk({tag, ".drv"}, data_rvalid, drv);
    chk({tag, ".ierr"}, instr_err, ierr);
    chk({tag, ".derr"}, data_err, derr);
    chk({tag, ".sel"}, wb_sel, sel);
    chk({tag, ".we"}, wb_we, we);
    chk({tag, ".adr"}, wb_adr, adr);
    chk({tag, ".dat_o"}, wb_dat_o, dat);
    chk({tag, ".irdata"}, instr_rdata, wb_dat_i);
    chk({tag, ".drdata"}, data_rdata, wb_dat_i);
  endtask

  task automatic drive(input logic ireq, dreq, stall, ack, err);
    instr_req = ireq; data_req = dreq; wb_stall = stall; wb_ack = ack; wb_err = err;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic ireq, dreq, stall, ack, err,
                              input logic stb, cyc, igt, dgt, irv, drv, derr,
                              input logic [3:0] sel, input logic we, input logic [31:0] adr, dat);
    vec_t v;
    v.ireq = ireq; v.dreq = dreq; v.stall = stall; v.ack = ack; v.err = err;
    v.stb = stb; v.cyc = cyc; v.igt = igt; v.dgt = dgt; v.irv = irv; v.drv = drv; v.derr = derr;
    v.sel = sel; v.we = we; v.adr = adr; v.dat = dat;
    return v;
  endfunction

  // Reference model state
  int m_owner;   // 0 none, 1 fetch, 2 data
  int m_n;
  int m_served;
  int m_prev;

  initial begin
    vec_t vecs[15];
    int   n_i, n_d, last_g, r;
    bit   own_req, oth, yld, e_stb, acc, rsp;
    logic [31:0] e_adr, e_dat;
    logic [3:0]  e_sel;
    bit   e_we;

    vecs[0]  = mk(1,0,0,0,0, 0,0,0,0,0,0,0, 4'h0,0,32'h0,32'h0);
    vecs[1]  = mk(1,0,0,0,0, 1,1,1,0,0,0,0, 4'hF,0,IA,32'h0);
    vecs[2]  = mk(1,0,0,0,0, 1,1,1,0,0,0,0, 4'hF,0,IA,32'h0);
    vecs[3]  = mk(1,0,0,0,0, 0,1,0,0,0,0,0, 4'hF,0,IA,32'h0);
    vecs[4]  = mk(1,0,0,1,0, 0,1,0,0,1,0,0, 4'hF,0,IA,32'h0);
    vecs[5]  = mk(1,0,0,1,0, 1,1,1,0,1,0,0, 4'hF,0,IA,32'h0);
    vecs[6]  = mk(0,0,0,0,0, 0,1,0,0,0,0,0, 4'hF,0,IA,32'h0);
    vecs[7]  = mk(0,0,0,0,0, 0,1,0,0,0,0,0, 4'hF,0,IA,32'h0);
    vecs[8]  = mk(0,0,0,1,0, 0,1,0,0,1,0,0, 4'hF,0,IA,32'h0);
    vecs[9]  = mk(0,0,0,1,0, 0,0,0,0,0,0,0, 4'h0,0,32'h0,32'h0);
    vecs[10] = mk(0,1,0,0,0, 0,0,0,0,0,0,0, 4'h0,0,32'h0,32'h0);
    vecs[11] = mk(0,1,1,0,0, 1,1,0,0,0,0,0, 4'h3,1,DA,WD);
    vecs[12] = mk(0,1,0,0,0, 1,1,0,1,0,0,0, 4'h3,1,DA,WD);
    vecs[13] = mk(0,0,0,0,1, 0,1,0,0,0,1,1, 4'h3,1,DA,WD);
    vecs[14] = mk(0,0,0,0,0, 0,0,0,0,0,0,0, 4'h0,0,32'h0,32'h0);

    rst_n = 1'b0;
    drive(1, 0, 0, 0, 0);
    instr_addr = IA; data_addr = DA; data_be = 4'b0011; data_we = 1'b1; data_wdata = WD;
    wb_dat_i = 32'h1234_5678;
    repeat (3) @(posedge clk);
    #1;
    chk_all("reset", 0,0,0,0,0,0,0,0, 4'h0, 0, 32'h0, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].ireq, vecs[i].dreq, vecs[i].stall, vecs[i].ack, vecs[i].err);
      wb_dat_i = 32'hA500_0000 + 32'(i);
      #1;
      chk_all($sformatf("vec%0d", i), vecs[i].stb, vecs[i].cyc, vecs[i].igt, vecs[i].dgt,
              vecs[i].irv, vecs[i].drv, 1'b0, vecs[i].derr, vecs[i].sel, vecs[i].we,
              vecs[i].adr, vecs[i].dat);
      next_cycle();
    end

    // Data request arrives while fetch has two transfers in flight
    drive(1, 0, 0, 0, 0); #1; chk("yld.idle_stb", wb_stb, 0); next_cycle();
    #1; chk("yld.gnt1", instr_gnt, 1); next_cycle();
    #1; chk("yld.gnt2", instr_gnt, 1); next_cycle();
    drive(1, 1, 0, 0, 0); #1;
    chk("yld.no_gnt", instr_gnt, 0); chk("yld.stb_low", wb_stb, 0); chk("yld.cyc_held", wb_cyc, 1);
    next_cycle();
    drive(1, 1, 0, 1, 0); #1;
    chk("yld.rv1", instr_rvalid, 1); chk("yld.no_gnt2", instr_gnt, 0); chk("yld.cyc1", wb_cyc, 1);
    next_cycle();
    #1; chk("yld.rv2", instr_rvalid, 1); chk("yld.cyc2", wb_cyc, 1); next_cycle();
    drive(1, 1, 0, 0, 0); #1;
    chk("yld.arb_cyc", wb_cyc, 0); chk("yld.arb_dgt", data_gnt, 0); next_cycle();
    #1;
    chk_all("yld.store", 1,1,0,1,0,0,0,0, 4'h3, 1, DA, WD);
    next_cycle();
    drive(1, 0, 0, 1, 0); #1; chk("yld.drv", data_rvalid, 1); next_cycle();
    drive(0, 0, 0, 0, 0); #1; chk("yld.end_cyc", wb_cyc, 0); next_cycle();
    next_cycle();

    // Both requesters held high with an always-acking slave
    n_i = 0; n_d = 0; last_g = 0;
    drive(1, 1, 0, 1, 0);
    for (int c = 0; c < 24; c++) begin
      #1;
      if (instr_gnt) begin
`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
        if (last_g != 0) chk("rr.alternate", last_g, 2);
`endif
        n_i++; last_g = 1;
      end
      if (data_gnt) begin
`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
        if (last_g != 0) chk("rr.alternate", last_g, 1);
`endif
        n_d++; last_g = 2;
      end
      next_cycle();
    end
`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
    chk("rr.instr_served", n_i >= 3, 1);
    chk("rr.data_served", n_d >= 3, 1);
`else
    chk("fixed.instr_grants", n_i, 0);
    chk("fixed.data_grants", n_d >= 10, 1);
`endif
    drive(0, 0, 0, 1, 0);
    repeat (3) next_cycle();
    #1; chk("both.drained_cyc", wb_cyc, 0);
    drive(0, 0, 0, 0, 0);
    next_cycle();

    // Asynchronous reset in the middle of a load
    drive(0, 1, 0, 0, 0); next_cycle();
    #1; chk("arst.pre_stb", wb_stb, 1); chk("arst.pre_dgt", data_gnt, 1); next_cycle();
    drive(0, 1, 1, 0, 0); #1; chk("arst.pre_cyc", wb_cyc, 1);
    #2; rst_n = 1'b0; #1;
    chk("arst.cyc", wb_cyc, 0); chk("arst.stb", wb_stb, 0); chk("arst.dgt", data_gnt, 0);
    drive(0, 0, 0, 1, 0);
    next_cycle();
    rst_n = 1'b1; #1;
    chk("arst.spur_drv", data_rvalid, 0); chk("arst.spur_irv", instr_rvalid, 0);
    next_cycle();
    #1; chk("arst.spur_drv2", data_rvalid, 0); chk("arst.spur_cyc", wb_cyc, 0);

    // Randomized traffic against the reference model, starting from reset state
    m_owner = 0; m_n = 0; m_served = 0; m_prev = 1;
    data_req = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      instr_req  = ($urandom_range(0, 3) != 0);
      data_req   = ($urandom_range(0, 4) == 0) || (data_req && $urandom_range(0, 2) != 0);
      wb_stall   = ($urandom_range(0, 3) == 0);
      r          = int'($urandom_range(0, 9));
      wb_ack     = (r < 4);
      wb_err     = (r == 4);
      wb_dat_i   = $urandom;
      instr_addr = $urandom & 32'hFFFF_FFFC;
      data_addr  = $urandom;
      data_be    = 4'($urandom_range(0, 15));
      data_we    = 1'($urandom_range(0, 1));
      data_wdata = $urandom;
      #1;
      own_req = 0; oth = 0; e_adr = '0; e_sel = '0; e_we = 0; e_dat = '0;
      if (m_owner == 1) begin
        own_req = instr_req; oth = data_req; e_adr = instr_addr; e_sel = 4'hF;
      end else if (m_owner == 2) begin
        own_req = data_req; oth = instr_req; e_adr = data_addr; e_sel = data_be;
        e_we = data_we; e_dat = data_wdata;
      end
`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
      yld = oth && (m_served > 0);
`else
      yld = (m_owner == 1) && oth;
`endif
      e_stb = own_req && !yld && (m_n < MAXO);
      acc   = e_stb && !wb_stall;
      rsp   = (wb_ack || wb_err) && (m_n > 0);
      chk_all("rnd", e_stb, e_stb || (m_n > 0), acc && m_owner == 1, acc && m_owner == 2,
              rsp && m_owner == 1, rsp && m_owner == 2, rsp && wb_err && m_owner == 1,
              rsp && wb_err && m_owner == 2, e_sel, e_we, e_adr, e_dat);
      m_n = m_n + int'(acc) - int'(rsp);
      if (m_owner != 0) begin
        m_served += int'(acc);
        if (m_n == 0 && (!own_req || yld)) m_owner = 0;
      end else if (data_req || instr_req) begin
`ifdef IBEX_WB_ARB_ROUND_ROBIN_EN
        if (data_req && instr_req) m_owner = (m_prev == 2) ? 1 : 2;
        else                       m_owner = data_req ? 2 : 1;
`else
        m_owner = data_req ? 2 : 1;
`endif
        m_prev   = m_owner;
        m_served = 0;
      end
      next_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ibex_wb_arbiter.md
Name: ibex_wb_arbiter

Overview:
- Shares one Wishbone B4 pipelined master port between the Ibex instruction-fetch and data ports.
- Sits between the ibex_core instr_*/data_* request/grant/rvalid interfaces and the system Wishbone interconnect.
- Only one requester owns the bus at a time. Ownership changes only after all of the owner's outstanding transfers have been acknowledged, so responses always go back to the correct port.

Parameters:
- MAX_OUTSTANDING, 2: maximum accepted-but-unacknowledged transfers per ownership; range 1..7.
- CNT_W, $clog2(MAX_OUTSTANDING+1): width of the outstanding counter (derived).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- instr_req  in  1  fetch request
- instr_gnt  out  1  fetch accepted
- instr_rvalid  out  1  fetch response valid
- instr_addr  in  32  fetch address, word aligned
- instr_rdata  out  32  fetch read data
- instr_err  out  1  fetch bus error
- data_req  in  1  load/store request
- data_gnt  out  1  load/store accepted
- data_rvalid  out  1  load/store response valid
- data_we  in  1  write enable
- data_be  in  4  byte enables
- data_addr  in  32  load/store address
- data_wdata  in  32  write data
- data_rdata  out  32  load read data
- data_err  out  1  load/store bus error
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_adr  out  32  Wishbone address
- wb_dat_o  out  32  Wishbone write data
- wb_we  out  1  Wishbone write enable
- wb_sel  out  4  Wishbone byte select
- wb_stall  in  1  slave stall
- wb_ack  in  1  slave acknowledge
- wb_err  in  1  slave error
- wb_dat_i  in  32  slave read data

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - state=IDLE, cnt=0.
  - All outputs 0: wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_o, both gnt, rvalid and err.
  - Reset asserted mid-transfer drops wb_cyc immediately; in-flight responses are discarded.
- FSM states: IDLE, OWN_I, OWN_D (registered).
- IDLE:
  - No strobe is driven.
  - If data_req: next state OWN_D; else if instr_req: next state OWN_I.
  - Arbitration costs exactly 1 cycle; the first wb_stb appears the cycle after the request is seen.
- Owner states:
  - wb_stb = owner_req & ~yield & (cnt < MAX_OUTSTANDING).
  - wb_adr/wb_sel/wb_we/wb_dat_o are muxed from the owner. For instr: sel=4'hF, we=0, dat_o=0.
  - owner_gnt = wb_stb & ~wb_stall. The non-owner's gnt is 0.
- Counter cnt:
  - +1 on accept (stb & ~stall); -1 on response (ack|err) while cnt!=0.
  - Accept and response in the same cycle: cnt unchanged.
  - ack/err with cnt==0 is ignored (no rvalid, no underflow).
- Responses:
  - owner_rvalid = (ack|err) & cnt!=0.
  - owner_err = err under the same qualification.
  - Both rdata outputs = wb_dat_i, unqualified. Non-owner rvalid/err is 0.
  - The slave must not assert ack and err together; if both are seen, a single rvalid with err=1 results.
- wb_cyc = (state!=IDLE) & (wb_stb | cnt!=0). Deasserts in the cycle after the last response.
- Yield (default, fixed data priority):
  - OWN_I yields when data_req=1.
  - OWN_D never yields while data_req=1.
- Release to IDLE: when the post-update cnt==0 and (owner_req==0 or yield). Then IDLE re-arbitrates the next cycle.
- MAX_OUTSTANDING full: stb is held low until a response frees a slot. A response and a new accept can occur in the same cycle.
- Ibex rule: a requester holding req without gnt must keep its address stable. The arbiter never grants without stb.

Optional Feature:
- Macro: IBEX_WB_ARB_ROUND_ROBIN_EN.
- Defined:
  - The owner yields when the other requester's req=1 and the owner has had ≥1 accept in this ownership.
  - IDLE picks the requester that was not the previous owner when both are requesting.
  - Previous owner is a 1-bit register, reset to instr.
- Not defined: fixed data priority as described under Behaviour; data can starve fetch.

Decomposition:
- Package ibex_wb_arb_pkg:
  - enum arb_state_t {IDLE, OWN_I, OWN_D}
  - typedef owner_t (1 bit: OWNER_I=0, OWNER_D=1)
  - localparam for the instruction sel value 4'hF.
- No sub-module; the FSM, counter and mux are inline.

Test Plan:
- Reset with instr_req=1, then release → IDLE; wb_stb rises 1 cycle after release; instr_gnt and wb_stb both high that cycle with wb_stall=0; wb_sel=4'hF, wb_we=0.
- Fetch ack latency 3, MAX_OUTSTANDING=2, continuous instr_req → at most 2 accepts before the first ack; stb drops while cnt=2; instr_rvalid pulses once per ack with instr_rdata=wb_dat_i.
- data_req rises while OWN_I has cnt=2 → no further instr_gnt; cyc held until both acks return; OWN_D on the next cycle; store of data_be=4'b0011, data_wdata=32'hDEADBEEF appears on wb_sel/wb_dat_o.
- wb_err on a load → data_rvalid=1 and data_err=1 in the same cycle; cnt returns to 0; cyc drops the following cycle.
- Spurious wb_ack with cnt=0 → no rvalid on either port, cnt stays 0; async rst_n low mid-transfer → wb_cyc/wb_stb low immediately, without waiting for a clock edge.
- IBEX_WB_ARB_ROUND_ROBIN_EN defined, both reqs held high → ownership alternates I/D after each single transfer drains; disabled → only data is served.
